// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// reference constants for the default single-precision format.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = 2**(EXP_W_DEF-1) - 1;
    localparam int EXP_MAX   = 2**EXP_W_DEF - 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_t;

    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_addsub_if.sv
// Issue-side and writeback-side bus of the FP add/sub unit.
// Valid/ready: a beat transfers on a rising edge where valid & ready are both 1;
// the source holds its payload stable while valid is high and ready is low.
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    parameter int DST_W = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   op;
    logic [EXP_W+MAN_W:0]   A;
    logic [EXP_W+MAN_W:0]   B;
    logic [TAG_W-1:0]       tag_in;
    logic [DST_W-1:0]       dst_in;
    logic                   wr_en_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   result;
    logic [TAG_W-1:0]       tag_out;
    logic [DST_W-1:0]       dst_out;
    logic                   wr_en_out;
    logic [2:0]             flags;

    modport master (
        output in_valid, op, A, B, tag_in, dst_in, wr_en_in, out_ready,
        input  in_ready, out_valid, result, tag_out, dst_out, wr_en_out, flags
    );

    modport slave (
        input  in_valid, op, A, B, tag_in, dst_in, wr_en_in, out_ready,
        output in_ready, out_valid, result, tag_out, dst_out, wr_en_out, flags
    );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter  int W  = 27,
    localparam int CW = $clog2(W+1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W-1-i);
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// Stallable 4-stage floating-point add/subtract: align, add, normalise,
// round/pack. Specials are resolved at alignment and ride down the pipe.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    parameter int DST_W = 5
) (
    input logic       clk,
    input logic       rst,
    fp_addsub_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int AW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int EW2 = EXP_W + 2;
    localparam int LZW = $clog2(AW+1);
    localparam logic [EXP_W-1:0] SH_CAP = EXP_W'(MAN_W + 3);
    localparam logic [EW2-1:0]   EMAX2  = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN_L = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DST_W-1:0] dst;
        logic             wr_en;
    } meta_t;

    typedef struct packed {
        logic valid; meta_t meta; logic special; logic [W-1:0] sp_res; logic [2:0] sp_flags;
        logic xs; logic ys; logic [EXP_W-1:0] ex; logic [AW-1:0] x_al; logic [AW-1:0] y_al;
    } s1_t;

    typedef struct packed {
        logic valid; meta_t meta; logic special; logic [W-1:0] sp_res; logic [2:0] sp_flags;
        logic sign; logic eff_sub; logic [EXP_W-1:0] ex; logic [SW-1:0] sum;
    } s2_t;

    typedef struct packed {
        logic valid; meta_t meta; logic special; logic [W-1:0] sp_res; logic [2:0] sp_flags;
        logic sign; logic zero; logic uf; logic [EW2-1:0] exp; logic [AW-1:0] man;
    } s3_t;

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) return FP_ZERO;
        if (e != '1) return FP_NORM;
        if (f == '0) return FP_INF;
        return f[MAN_W-1] ? FP_QNAN : FP_SNAN;
    endfunction

    s1_t s1, n1;
    s2_t s2, n2;
    s3_t s3, n3;
    logic adv;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // S1: classify, order by magnitude, align the smaller operand
    fp_class_t        cls_a, cls_b;
    logic             a_s, b_s, swap, a_nan, b_nan;
    logic [W-2:0]     a_mag, b_mag, x_mag, y_mag;
    logic [MAN_W:0]   x_man, y_man;
    logic [EXP_W-1:0] diff;
    logic [AW-1:0]    y_sh, y_lost;

    always_comb begin
        n1    = '0;
        cls_a = classify(bus.A[W-2:MAN_W], bus.A[MAN_W-1:0]);
        cls_b = classify(bus.B[W-2:MAN_W], bus.B[MAN_W-1:0]);
        a_s   = bus.A[W-1];
        b_s   = bus.B[W-1] ^ bus.op;
        a_mag = (cls_a == FP_ZERO) ? '0 : bus.A[W-2:0];
        b_mag = (cls_b == FP_ZERO) ? '0 : bus.B[W-2:0];
        swap  = b_mag > a_mag;
        x_mag = swap ? b_mag : a_mag;
        y_mag = swap ? a_mag : b_mag;
        x_man = {|x_mag[W-2:MAN_W], x_mag[MAN_W-1:0]};
        y_man = {|y_mag[W-2:MAN_W], y_mag[MAN_W-1:0]};
        diff  = x_mag[W-2:MAN_W] - y_mag[W-2:MAN_W];
        {y_sh, y_lost} = {y_man, 3'b000, {AW{1'b0}}} >> diff;

        n1.valid = bus.in_valid;
        n1.meta  = {bus.tag_in, bus.dst_in, bus.wr_en_in};
        n1.xs    = swap ? b_s : a_s;
        n1.ys    = swap ? a_s : b_s;
        n1.ex    = x_mag[W-2:MAN_W];
        n1.x_al  = {x_man, 3'b000};
        if (diff >= SH_CAP) n1.y_al = {{(AW-1){1'b0}}, |y_man};
        else                n1.y_al = {y_sh[AW-1:1], y_sh[0] | (|y_lost)};

        a_nan = (cls_a == FP_QNAN) || (cls_a == FP_SNAN);
        b_nan = (cls_b == FP_QNAN) || (cls_b == FP_SNAN);
        if (a_nan || b_nan) begin
            n1.special = 1'b1;
            n1.sp_res  = QNAN_L;
            n1.sp_flags[FLAG_INV] = (cls_a == FP_SNAN) || (cls_b == FP_SNAN);
        end else if (cls_a == FP_INF && cls_b == FP_INF && a_s != b_s) begin
            n1.special = 1'b1;
            n1.sp_res  = QNAN_L;
            n1.sp_flags[FLAG_INV] = 1'b1;
        end else if (cls_a == FP_INF) begin
            n1.special = 1'b1;
            n1.sp_res  = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_b == FP_INF) begin
            n1.special = 1'b1;
            n1.sp_res  = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // S2: magnitude add/subtract; X >= Y so the difference never goes negative
    always_comb begin
        n2          = '0;
        n2.valid    = s1.valid;
        n2.meta     = s1.meta;
        n2.special  = s1.special;
        n2.sp_res   = s1.sp_res;
        n2.sp_flags = s1.sp_flags;
        n2.sign     = s1.xs;
        n2.eff_sub  = s1.xs != s1.ys;
        n2.ex       = s1.ex;
        n2.sum      = n2.eff_sub ? ({1'b0, s1.x_al} - {1'b0, s1.y_al})
                                 : ({1'b0, s1.x_al} + {1'b0, s1.y_al});
    end

    // S3: normalise
    logic [LZW-1:0] lz;
    fp_lzc #(.W(AW)) u_lzc (.value(s2.sum[AW-1:0]), .count(lz));

    always_comb begin
        n3          = '0;
        n3.valid    = s2.valid;
        n3.meta     = s2.meta;
        n3.special  = s2.special;
        n3.sp_res   = s2.sp_res;
        n3.sp_flags = s2.sp_flags;
        n3.sign     = s2.sign;
        n3.exp      = {2'b00, s2.ex};
        n3.man      = s2.sum[AW-1:0];
        if (s2.sum[SW-1]) begin
            n3.man = {s2.sum[SW-1:2], s2.sum[1] | s2.sum[0]};
            n3.exp = n3.exp + EW2'(1);
        end else if (s2.sum == '0) begin
            // an exact cancellation is +0; only two like-signed zeros keep their sign
            n3.zero = 1'b1;
            n3.sign = s2.sign & ~s2.eff_sub;
        end else begin
            n3.man = s2.sum[AW-1:0] << lz;
            n3.exp = n3.exp - EW2'(lz);
            if (n3.exp[EW2-1] || n3.exp == '0) begin
                n3.zero = 1'b1;
                n3.uf   = 1'b1;
            end
        end
    end

    // S4: round to nearest even and pack
    logic             g, r, st, inc;
    logic [MAN_W+1:0] m_r;
    logic [EW2-1:0]   r_exp;
    logic [MAN_W-1:0] r_frac;
    logic [W-1:0]     n4_res;
    logic [2:0]       n4_flags;

    always_comb begin
        g        = s3.man[2];
        r        = s3.man[1];
        st       = s3.man[0];
        inc      = g & (r | st | s3.man[3]);
        m_r      = {1'b0, s3.man[AW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        r_exp    = s3.exp;
        r_frac   = m_r[MAN_W-1:0];
        if (m_r[MAN_W+1]) begin
            r_exp  = r_exp + EW2'(1);
            r_frac = m_r[MAN_W:1];
        end
        n4_flags = '0;
        if (s3.special) begin
            n4_res   = s3.sp_res;
            n4_flags = s3.sp_flags;
        end else if (s3.zero) begin
            n4_res = {s3.sign, {(W-1){1'b0}}};
            n4_flags[FLAG_INX] = s3.uf;
        end else if (r_exp >= EMAX2) begin
            n4_res = {s3.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            n4_flags[FLAG_OVF] = 1'b1;
            n4_flags[FLAG_INX] = 1'b1;
        end else begin
            n4_res = {s3.sign, r_exp[EXP_W-1:0], r_frac};
            n4_flags[FLAG_INX] = g | r | st;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
            bus.tag_out   <= '0;
            bus.dst_out   <= '0;
            bus.wr_en_out <= 1'b0;
        end else if (adv) begin
            s1            <= n1;
            s2            <= n2;
            s3            <= n3;
            bus.out_valid <= s3.valid;
            bus.result    <= n4_res;
            bus.flags     <= n4_flags;
            bus.tag_out   <= s3.meta.tag;
            bus.dst_out   <= s3.meta.dst;
            bus.wr_en_out <= s3.meta.wr_en;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: hand-computed single-precision vectors,
// latency, back-pressure stability and mid-flight reset.
module tb_fp_addsub_pipe;
    import fp_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int DST_W = 5;
    localparam int EW    = 32 + 3 + TAG_W + DST_W + 1;
    localparam int NV    = 18;

    // row = {A, B, op, expected result, expected {invalid, overflow, inexact}}
    localparam logic [99:0] VEC [NV] = '{
        {32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000},
        {32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
        {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011},
        {32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001},
        {32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001},
        {32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100},
        {32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100},
        {32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},
        {32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
        {32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},
        {32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000},
        {32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001},
        {32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001},
        {32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 3'b011},
        {32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000},
        {32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000},
        {32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000},
        {32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000}
    };

    logic clk;
    logic rst;

    fp_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W), .DST_W(DST_W)) bus ();

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W), .DST_W(DST_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int             n_cmp;
    int             n_err;
    logic [EW-1:0]  exp_q [$];
    logic [TAG_W-1:0] tag_cnt;
    logic           mon_en;
    logic           prev_stall;
    logic [EW:0]    snap;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, obs, expv, $time);
        end
    endtask

    // driver
    task automatic send_vec(input int idx);
        logic [99:0] row;
        logic        acc;
        row          = VEC[idx];
        bus.A        = row[99:68];
        bus.B        = row[67:36];
        bus.op       = row[35];
        bus.tag_in   = tag_cnt;
        bus.dst_in   = tag_cnt ^ 5'h15;
        bus.wr_en_in = tag_cnt[0];
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check_eq("in_accept", 64'(acc), 64'(1));
        if (acc) exp_q.push_back({row[34:3], row[2:0], tag_cnt, tag_cnt ^ 5'h15, tag_cnt[0]});
        tag_cnt++;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq(name, 64'(exp_q.size()), 64'(0));
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en && rst) begin
            if (prev_stall)
                check_eq("stall_hold", 64'({bus.out_valid, bus.result, bus.flags, bus.tag_out,
                                            bus.dst_out, bus.wr_en_out}), 64'(snap));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", 64'(bus.result), 64'(e[45:14]));
                    check_eq("flags", 64'(bus.flags), 64'(e[13:11]));
                    check_eq("tag_dst_wr", 64'({bus.tag_out, bus.dst_out, bus.wr_en_out}), 64'(e[10:0]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            snap = {bus.out_valid, bus.result, bus.flags, bus.tag_out, bus.dst_out, bus.wr_en_out};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        tag_cnt      = '0;
        mon_en       = 1'b0;
        prev_stall   = 1'b0;
        snap         = '0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.tag_in   = '0;
        bus.dst_in   = '0;
        bus.wr_en_in = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_eq("rst_result", 64'(bus.result), 64'(0));
        check_eq("rst_flags", 64'(bus.flags), 64'(0));
        check_eq("rst_meta", 64'({bus.tag_out, bus.dst_out, bus.wr_en_out}), 64'(0));
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // single op: output appears on the 4th edge after the capturing edge's predecessor
        send_vec(0);
        idle();
        repeat (2) @(posedge clk);
        #1 check_eq("latency_early", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1 check_eq("latency_4", 64'(bus.out_valid), 64'(1));
        drain("drain_single");

        // every directed vector, back to back
        for (int i = 0; i < NV; i++) send_vec(i);
        idle();
        drain("drain_vectors");

        // back-pressure: out_ready low for cycles 3-6 of an 8-op burst
        fork
            begin
                for (int i = 0; i < 8; i++) send_vec(i);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // reset with three ops in flight discards them
        for (int i = 0; i < 3; i++) send_vec(i + 2);
        idle();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_eq("midrst_no_ghost", 64'(bus.out_valid), 64'(0));
        send_vec(16);
        idle();
        drain("drain_after_rst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
